// File: rtl/ysig_pkg.sv
// Shared definitions for the y_signature_collector capture stage:
// bus width, default MISR feedback taps and the FSM state type.
package ysig_pkg;

  localparam int unsigned Y_W = 119;

  localparam logic [Y_W-1:0] POLY_DEFAULT = 119'h201;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } ysig_state_t;

endpackage : ysig_pkg

// File: rtl/ysig_misr_step.sv
// One MISR step: shift the signature left, fold the feedback taps in when
// the MSB falls off, then XOR the incoming sample. Purely combinational.
module ysig_misr_step #(
  parameter int unsigned W = 119
) (
  input  logic [W-1:0] sig,
  input  logic [W-1:0] y,
  input  logic [W-1:0] poly,
  output logic [W-1:0] sig_next
);

  logic [W-1:0] shifted;

  // Shift, conditional feedback, sample fold
  always_comb begin
    shifted  = {sig[W-2:0], 1'b0};
    sig_next = (sig[W-1] ? (shifted ^ poly) : shifted) ^ y;
  end

endmodule : ysig_misr_step

// File: rtl/y_signature_collector.sv
// Capture stage that compresses a programmed number of y samples into a
// MISR signature and flags completion.
// Optional feature: define YSIG_COMPARE_EN to add expected_sig input and
// pass/fail outputs evaluated while the run is complete.
module y_signature_collector #(
  parameter int unsigned      Y_W   = ysig_pkg::Y_W,
  parameter logic [Y_W-1:0]   POLY  = Y_W'(ysig_pkg::POLY_DEFAULT),
  parameter logic [Y_W-1:0]   SEED  = '0,
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [Y_W-1:0]   y,
  input  logic             y_valid,
`ifdef YSIG_COMPARE_EN
  input  logic [Y_W-1:0]   expected_sig,
  output logic             pass,
  output logic             fail,
`endif
  output logic             busy,
  output logic             done,
  output logic [Y_W-1:0]   signature,
  output logic [CNT_W-1:0] samples_left
);

  import ysig_pkg::*;

  ysig_state_t      state_q, state_d;
  logic [Y_W-1:0]   sig_q, sig_d, sig_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef YSIG_COMPARE_EN
  logic [Y_W-1:0]   exp_q, exp_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
`endif

  ysig_misr_step #(
    .W (Y_W)
  ) u_step (
    .sig      (sig_q),
    .y        (y),
    .poly     (POLY),
    .sig_next (sig_step)
  );

  // Next-state, counter and signature update; flags follow the next state
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
`ifdef YSIG_COMPARE_EN
    exp_d   = exp_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = num_samples;
`ifdef YSIG_COMPARE_EN
          exp_d   = expected_sig;
`endif
          state_d = (num_samples == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (y_valid) begin
          sig_d = sig_step;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CAPTURE);
    done_d = (state_d == DONE);
`ifdef YSIG_COMPARE_EN
    pass_d = done_d && (sig_d == exp_d);
    fail_d = done_d && (sig_d != exp_d);
`endif
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef YSIG_COMPARE_EN
      exp_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef YSIG_COMPARE_EN
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign signature    = sig_q;
  assign samples_left = cnt_q;
`ifdef YSIG_COMPARE_EN
  assign pass         = pass_q;
  assign fail         = fail_q;
`endif

endmodule : y_signature_collector

// File: doc/y_signature_collector.md
# y_signature_collector

Downstream capture stage for the 119-bit `y` result bus of the fuzzed `top` design. It compresses a programmed number of `y` samples into a 119-bit MISR signature, then reports completion. The synthesized and reference netlists can then be compared by signature instead of by per-cycle `$strobe` text. It sits between `top1.y` and the bench's checker, clocked by the same `clk`.

## Interface
Parameters:
- `Y_W`, 119, width of the `y` bus and of the signature.
- `POLY`, 119'h201, MISR feedback taps XORed in when the signature MSB shifts out.
- `SEED`, 119'h0, signature value loaded on `start`.
- `CNT_W`, 8, width of the sample counter.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request to begin a capture run.
- `num_samples`  input  CNT_W  samples to fold in; sampled on an accepted `start`.
- `y`  input  Y_W  result bus from `top`.
- `y_valid`  input  1  `y` is a sample to fold this cycle.
- `busy`  output  1  run in progress.
- `done`  output  1  run complete; `signature` is final.
- `signature`  output  Y_W  running/final MISR value.
- `samples_left`  output  CNT_W  remaining samples in the run.

## Operation
- FSM states are IDLE, CAPTURE and DONE. Reset puts the FSM in IDLE with `busy`=0, `done`=0, `signature`=SEED and `samples_left`=0.
- In IDLE or DONE, `start`=1 has the following effect:
  - load `signature`=SEED and `samples_left`=`num_samples`;
  - clear `done`;
  - go to CAPTURE, or go to DONE if `num_samples`==0.
- In CAPTURE, `start` is ignored.
- In CAPTURE with `y_valid`=1:
  - `signature` <= ({signature[Y_W-2:0],1'b0} ^ (signature[Y_W-1] ? POLY : 0)) ^ `y`;
  - `samples_left` decrements.
  - When `samples_left`==1, the FSM moves to DONE.
- In CAPTURE with `y_valid`=0, all state holds.
- DONE holds `done`=1 and a frozen `signature` until the next accepted `start`.
- `busy`=1 exactly in CAPTURE.
- All arithmetic is modulo 2 and unsigned. The counter never wraps below 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `start` in cycle N gives `busy`=1 in N+1, or `done`=1 in N+1 when `num_samples`==0.
- The k-th valid sample in cycle M is reflected in `signature` at M+1.
- The final sample in cycle M gives `done`=1 and the final `signature` at M+1. Latency from `start` to `done` is `num_samples`+1 cycles when `y_valid` is held high.
- `start` together with `y_valid` in IDLE/DONE: the sample is not folded, and the run begins next cycle.
- If `rst_n` is asserted mid-run, all state clears immediately, asynchronously. The run is lost and no `done` is produced.

## Configuration
- `YSIG_COMPARE_EN` defined adds two inputs and two outputs:
  - input `expected_sig` [Y_W-1:0], registered on an accepted `start`;
  - outputs `pass` and `fail`, each 1 bit, reset 0.
- In DONE, `pass`=(`signature`==expected) and `fail`=!pass. Outside DONE, both are 0.
- Without the macro, these ports and the compare register do not exist. The remaining behaviour is identical.

## Structure
- Package `ysig_pkg` holds:
  - `Y_W`;
  - the default `POLY`;
  - the FSM state typedef `ysig_state_t` {IDLE, CAPTURE, DONE}.
- Sub-module `ysig_misr_step` is a purely combinational next-signature function (sig, y, poly -> sig_next). The top module holds the FSM, the counter and the registers.

## Test plan
- Reset mid-CAPTURE (`num_samples`=5, after 2 samples): immediately `busy`=0, `done`=0, `signature`=0, `samples_left`=0.
- `num_samples`=1, `y`=all-ones, `y_valid`=1 -> `done`=1 two cycles after `start`, `signature`=119'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF (all ones).
- `num_samples`=2:
  - `y`=1<<118 then `y`=0 -> `signature`=POLY (119'h201);
  - `y`=1 then 1 -> `signature`=119'h3.
- `num_samples`=3 with `y_valid` toggling 1,0,1,0,1 -> `done` after the fifth capture cycle. A `start` pulsed mid-run is ignored and `samples_left` reads 2,2,1,1,0.
- `num_samples`=0 -> `done`=1 the cycle after `start`, `signature`=SEED. A new `start` in DONE clears `done` and reruns.
- `YSIG_COMPARE_EN`, `num_samples`=1, `y`=1:
  - `expected_sig`=1 -> `pass`=1, `fail`=0;
  - `expected_sig`=2 -> `pass`=0, `fail`=1.
